// File: rtl/vga_timing_gen.sv
// 800x600@60 VGA raster timing from a 40 MHz pixel clock. Presents pixel
// coordinates to a renderer and drives registered pins aligned to its latency.
package project;
  localparam int SCREEN_WIDTH  = 800;
  localparam int SCREEN_HEIGHT = 600;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] x;
  } coord_t;

  typedef logic [23:0] rgb_t;
endpackage

module vga_timing_gen
  import project::*;
#(
  parameter int H_ACTIVE   = SCREEN_WIDTH,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = SCREEN_HEIGHT,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int RENDER_LAT = 2
) (
  input  logic   clk,
  input  logic   rst,
  output coord_t pix_coord,
  output logic   pix_valid,
  output logic   line_start,
  output logic   frame_start,
  input  rgb_t   rgb_in,
  output rgb_t   vga_rgb,
  output logic   vga_hs,
  output logic   vga_vs,
  output logic   vga_de
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_wrap;
  logic          w_v_wrap;

  assign w_h_wrap = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_wrap = (r_v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end
    end
  end

  logic w_active;
  logic w_hs;
  logic w_vs;
  logic w_h_zero;
  logic w_v_zero;

  assign w_h_zero = (r_h_cnt == '0);
  assign w_v_zero = (r_v_cnt == '0);
  assign w_active = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign w_hs     = (r_h_cnt >= HW'(HS_START)) && (r_h_cnt <= HW'(HS_END));
  // vsync is decoded from the line count only, so it spans whole lines
  assign w_vs     = (r_v_cnt >= VW'(VS_START)) && (r_v_cnt <= VW'(VS_END));

  coord_t r_coord;
  logic   r_active;
  logic   r_line_start;
  logic   r_frame_start;
  logic   r_hs_s1;
  logic   r_vs_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_coord       <= '0;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs_s1       <= 1'b0;
      r_vs_s1       <= 1'b0;
    end else begin
      r_coord       <= w_active ? coord_t'({10'(r_v_cnt), 10'(r_h_cnt)}) : '0;
      r_active      <= w_active;
      r_line_start  <= w_active && w_h_zero;
      r_frame_start <= w_h_zero && w_v_zero;
      r_hs_s1       <= w_hs;
      r_vs_s1       <= w_vs;
    end
  end

  assign pix_coord   = r_coord;
  assign pix_valid   = r_active;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

  // Delayed {hs, vs, active}; matches the renderer's pipeline depth.
  logic [2:0] w_dly;

  generate
    if (RENDER_LAT == 0) begin : g_no_dly
      assign w_dly = {r_hs_s1, r_vs_s1, r_active};
    end else begin : g_dly
      logic [RENDER_LAT-1:0][2:0] r_dly;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_dly <= '0;
        end else begin
          r_dly[0] <= {r_hs_s1, r_vs_s1, r_active};
          for (int i = 1; i < RENDER_LAT; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end

      assign w_dly = r_dly[RENDER_LAT-1];
    end
  endgenerate

  rgb_t r_vga_rgb;
  logic r_vga_hs;
  logic r_vga_vs;
  logic r_vga_de;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vga_rgb <= '0;
      r_vga_hs  <= 1'b0;
      r_vga_vs  <= 1'b0;
      r_vga_de  <= 1'b0;
    end else begin
      r_vga_rgb <= w_dly[0] ? rgb_in : '0;
      r_vga_hs  <= w_dly[2];
      r_vga_vs  <= w_dly[1];
      r_vga_de  <= w_dly[0];
    end
  end

  assign vga_rgb = r_vga_rgb;
  assign vga_hs  = r_vga_hs;
  assign vga_vs  = r_vga_vs;
  assign vga_de  = r_vga_de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (RENDER_LAT 2 and 0) with a short
// vertical frame, a renderer model feeding a pixel scoreboard, and timing checks.
module tb_vga_timing_gen;
  import project::*;

  localparam int HT  = 1056;
  localparam int HA  = 800;
  localparam int HS0 = 840;
  localparam int HS1 = 967;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int VT  = VA + VFP + VSW + VBP;

  typedef struct packed {
    logic        pv;
    logic [19:0] coord;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        de;
  } obs_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   meas_en = 1'b1;

  coord_t pc_a, pc_b;
  logic   pv_a, pv_b, ls_a, ls_b, fs_a, fs_b;
  logic   hs_a, hs_b, vs_a, vs_b, de_a, de_b;
  rgb_t   rgb_a, rgb_b, vrgb_a, vrgb_b;

  int n_tests = 0;
  int n_fail  = 0;

  int         t_c[2]        = '{0, 0};
  logic [1:0] prev_rst      = 2'b11;
  logic [20:0] hist[2][16];
  rgb_t       q_a[$];
  rgb_t       q_b[$];

  int   pv_line[2]    = '{0, 0};
  int   ls2[2]        = '{0, 0};
  int   fs2[2]        = '{0, 0};
  int   hs_cnt[2]     = '{0, 0};
  int   hs_rise[2]    = '{0, 0};
  int   vs_cnt[2]     = '{0, 0};
  int   vs_first[2]   = '{0, 0};
  int   de_cnt[2]     = '{0, 0};
  int   first_de_t[2] = '{0, 0};
  rgb_t first_rgb[2]  = '{24'h0, 24'h0};
  rgb_t last_rgb[2]   = '{24'h0, 24'h0};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .RENDER_LAT(2)
  ) u_lat2 (
    .clk(clk), .rst(rst),
    .pix_coord(pc_a), .pix_valid(pv_a), .line_start(ls_a), .frame_start(fs_a),
    .rgb_in(rgb_a), .vga_rgb(vrgb_a), .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a)
  );

  vga_timing_gen #(
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .RENDER_LAT(0)
  ) u_lat0 (
    .clk(clk), .rst(rst),
    .pix_coord(pc_b), .pix_valid(pv_b), .line_start(ls_b), .frame_start(fs_b),
    .rgb_in(rgb_b), .vga_rgb(vrgb_b), .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected outputs in cycle t after the first un-reset edge (t=0: in reset).
  function automatic obs_t model(input int t, input int rl);
    obs_t o;
    int p, h, v, q, hq, vq;
    o = '0;
    if (t >= 1) begin
      p = t - 1;
      h = p % HT;
      v = (p / HT) % VT;
      o.pv    = (h < HA) && (v < VA);
      o.coord = o.pv ? {10'(v), 10'(h)} : 20'h0;
      o.ls    = o.pv && (h == 0);
      o.fs    = (h == 0) && (v == 0);
    end
    q = t - rl - 2;
    if (q >= 0) begin
      hq = q % HT;
      vq = (q / HT) % VT;
      o.de = (hq < HA) && (vq < VA);
      o.hs = (hq >= HS0) && (hq <= HS1);
      o.vs = (vq >= VA + VFP) && (vq <= VA + VFP + VSW - 1);
    end
    return o;
  endfunction

  task automatic mon(input int k, input int rl, input obs_t got, input rgb_t vrgb,
                     output rgb_t drv);
    obs_t        ex;
    rgb_t        e;
    logic [20:0] h;
    int          t;
    if (prev_rst[k]) t_c[k] = 0;
    else t_c[k] = t_c[k] + 1;
    t  = t_c[k];
    ex = model(t, rl);
    chk($sformatf("timing[lat%0d] t=%0d", rl, t), 32'(got), 32'(ex));

    if (got.de) begin
      if ((k == 0 ? q_a.size() : q_b.size()) == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pixel[lat%0d] t=%0d: got %0h expected none queued", rl, t, vrgb);
      end else begin
        if (k == 0) e = q_a.pop_front();
        else e = q_b.pop_front();
        chk($sformatf("pixel[lat%0d] t=%0d", rl, t), 32'(vrgb), 32'(e));
      end
    end else begin
      chk($sformatf("blank[lat%0d] t=%0d", rl, t), 32'(vrgb), 32'h0);
    end

    if (meas_en && t >= 1 && t <= HT * VT + 1) begin
      if (t <= HT && got.pv) pv_line[k]++;
      if (t <= HT && got.hs) hs_cnt[k]++;
      if (got.ls && t > 1 && ls2[k] == 0) ls2[k] = t;
      if (got.fs && t > 1 && fs2[k] == 0) fs2[k] = t;
      if (got.hs && hs_rise[k] == 0) hs_rise[k] = t;
      if (got.vs) vs_cnt[k]++;
      if (got.vs && vs_first[k] == 0) vs_first[k] = t;
      if (got.de) begin
        de_cnt[k]++;
        last_rgb[k] = vrgb;
        if (first_de_t[k] == 0) begin
          first_de_t[k] = t;
          first_rgb[k]  = vrgb;
        end
      end
    end

    // Renderer: answer the coordinate seen rl cycles ago, white otherwise.
    for (int i = 15; i > 0; i--) hist[k][i] = hist[k][i-1];
    hist[k][0] = {got.pv, got.coord};
    if (rst) begin
      for (int i = 0; i < 16; i++) hist[k][i] = '0;
      if (k == 0) q_a.delete();
      else q_b.delete();
    end
    h = hist[k][rl];
    if (h[20] && !rst) begin
      drv = {h[7:0], h[17:10], 8'hA5};
      if (k == 0) q_a.push_back(drv);
      else q_b.push_back(drv);
    end else begin
      drv = 24'hFFFFFF;
    end
    prev_rst[k] = rst;
  endtask

  initial begin : mon_a
    rgb_t d;
    rgb_a = 24'hFFFFFF;
    forever begin
      @(negedge clk);
      mon(0, 2, {pv_a, pc_a, ls_a, fs_a, hs_a, vs_a, de_a}, vrgb_a, d);
      rgb_a = d;
    end
  end

  initial begin : mon_b
    rgb_t d;
    rgb_b = 24'hFFFFFF;
    forever begin
      @(negedge clk);
      mon(1, 0, {pv_b, pc_b, ls_b, fs_b, hs_b, vs_b, de_b}, vrgb_b, d);
      rgb_b = d;
    end
  end

  task automatic restart_after(input int n);
    repeat (n) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : stim
    int rl;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    // Two full frames, then a reset while stage 1 shows (3,500).
    repeat (2 * HT * VT + 3 * HT + 500 + 1) @(posedge clk);
    meas_en = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Reset while stage 1 and the pins are inside hsync (line 1, x=900).
    restart_after(HT + 900 + 1);
    repeat (HT * VT + HT) @(posedge clk);
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      rl = (k == 0) ? 2 : 0;
      chk($sformatf("pv_per_line[lat%0d]", rl), 32'(pv_line[k]), 32'd800);
      chk($sformatf("line_period[lat%0d]", rl), 32'(ls2[k] - 1), 32'd1056);
      chk($sformatf("hs_width[lat%0d]", rl), 32'(hs_cnt[k]), 32'd128);
      chk($sformatf("hs_offset[lat%0d]", rl), 32'(hs_rise[k] - 1), 32'(840 + rl + 1));
      chk($sformatf("frame_period[lat%0d]", rl), 32'(fs2[k] - 1), 32'd12672);
      chk($sformatf("de_per_frame[lat%0d]", rl), 32'(de_cnt[k]), 32'd4800);
      chk($sformatf("vs_width[lat%0d]", rl), 32'(vs_cnt[k]), 32'd2112);
      chk($sformatf("vs_offset[lat%0d]", rl), 32'(vs_first[k] - 1), 32'(7 * 1056 + rl + 1));
      chk($sformatf("pin_latency[lat%0d]", rl), 32'(first_de_t[k] - 1), 32'(rl + 1));
      chk($sformatf("first_rgb[lat%0d]", rl), 32'(first_rgb[k]), 32'h0000A5);
      chk($sformatf("last_rgb[lat%0d]", rl), 32'(last_rgb[k]), 32'h1F05A5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
